// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-channel packet-locking stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/stream_mux_skid.sv
// Two-entry register slice; only exists in builds with STREAM_MUX_OUT_REG_EN defined.
`ifdef STREAM_MUX_OUT_REG_EN
module stream_mux_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         skid_valid;
    logic [W-1:0] skid_data;

    // Ready depends only on registered state, breaking the downstream ready path.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule
`endif

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream mux with packet locking, fixed or round-robin selection.
// Define STREAM_MUX_OUT_REG_EN to register the output through a 2-entry skid slice.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   MUX_clk,
    input  logic                   MUX_rst,
    input  logic                   MUX_en,
    input  logic                   MUX_mode,
    input  logic [SEL_W-1:0]       MUX_sel,
    input  logic [N_CH-1:0]        MUX_in_valid,
    input  logic [N_CH*DATA_W-1:0] MUX_in_data,
    input  logic [N_CH-1:0]        MUX_in_last,
    output logic [N_CH-1:0]        MUX_in_ready,
    output logic                   MUX_out_valid,
    output logic [DATA_W-1:0]      MUX_out_data,
    output logic                   MUX_out_last,
    input  logic                   MUX_out_ready,
    output logic [SEL_W-1:0]       MUX_out_ch,
    output logic                   MUX_busy
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  grant_q, rr_ptr_q, cand, rr_idx;
    logic [SEL_W:0]    rr_sum;
    logic              cand_found, lock_act, fwd_ready, in_hs, pkt_end;
    logic              sel_valid, sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] ch_data [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign ch_data[k] = MUX_in_data[k*DATA_W +: DATA_W];
    end

    // Reset gates the lock combinationally so the beat on the reset cycle never transfers.
    assign lock_act = (state_q == ST_LOCK) && !MUX_rst;
    assign MUX_busy = lock_act;

    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        rr_sum     = '0;
        rr_idx     = '0;
        if (MUX_mode == MODE_FIXED) begin
            if ((32'(MUX_sel) < N_CH) && MUX_in_valid[MUX_sel]) begin
                cand       = MUX_sel;
                cand_found = 1'b1;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                rr_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
                if (rr_sum >= (SEL_W+1)'(N_CH)) rr_sum = rr_sum - (SEL_W+1)'(N_CH);
                rr_idx = rr_sum[SEL_W-1:0];
                if (!cand_found && MUX_in_valid[rr_idx]) begin
                    cand       = rr_idx;
                    cand_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_valid = MUX_in_valid[grant_q];
        sel_last  = MUX_in_last[grant_q];
        sel_data  = ch_data[grant_q];
    end

    assign in_hs   = lock_act && sel_valid && fwd_ready;
    assign pkt_end = in_hs && sel_last;

    always_comb begin
        MUX_in_ready = '0;
        if (lock_act) MUX_in_ready[grant_q] = fwd_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (MUX_en && cand_found) state_d = ST_LOCK;
            ST_LOCK: if (pkt_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge MUX_clk) begin
        if (MUX_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_LOCK) grant_q <= cand;
            if (pkt_end) rr_ptr_q <= SEL_W'(rr_next(32'(grant_q), N_CH));
        end
    end

`ifdef STREAM_MUX_OUT_REG_EN
    localparam int PW = SEL_W + 1 + DATA_W;
    logic [PW-1:0] skid_out;

    stream_mux_skid #(.W(PW)) u_skid (
        .clk       (MUX_clk),
        .rst       (MUX_rst),
        .in_valid  (lock_act && sel_valid),
        .in_data   ({grant_q, sel_last, sel_data}),
        .in_ready  (fwd_ready),
        .out_valid (MUX_out_valid),
        .out_data  (skid_out),
        .out_ready (MUX_out_ready)
    );

    assign {MUX_out_ch, MUX_out_last, MUX_out_data} = skid_out;
`else
    assign fwd_ready     = MUX_out_ready;
    assign MUX_out_valid = lock_act && sel_valid;
    assign MUX_out_data  = lock_act ? sel_data : '0;
    assign MUX_out_last  = lock_act && sel_last;
    assign MUX_out_ch    = lock_act ? grant_q : '0;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: a 4-channel and a 3-channel instance driven from beat queues.
module tb_stream_mux_n;
    import stream_mux_pkg::*;

    localparam int DW = 8;
    typedef logic [DW:0]   beat_t;   // {last, data}
    typedef logic [DW+2:0] obs_t;    // {ch, last, data}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            en4 = 1'b0, mode4 = 1'b0, ordy4 = 1'b1;
    logic [1:0]      sel4 = '0;
    logic [3:0]      v4 = '0, l4 = '0, r4;
    logic [4*DW-1:0] d4 = '0;
    logic            ov4, ol4, busy4;
    logic [DW-1:0]   od4;
    logic [1:0]      och4;

    logic            en3 = 1'b0, mode3 = 1'b0, ordy3 = 1'b1;
    logic [1:0]      sel3 = '0;
    logic [2:0]      v3 = '0, l3 = '0, r3;
    logic [3*DW-1:0] d3 = '0;
    logic            ov3, ol3, busy3;
    logic [DW-1:0]   od3;
    logic [1:0]      och3;

    stream_mux_n dut4 (
        .MUX_clk(clk), .MUX_rst(rst), .MUX_en(en4), .MUX_mode(mode4), .MUX_sel(sel4),
        .MUX_in_valid(v4), .MUX_in_data(d4), .MUX_in_last(l4), .MUX_in_ready(r4),
        .MUX_out_valid(ov4), .MUX_out_data(od4), .MUX_out_last(ol4),
        .MUX_out_ready(ordy4), .MUX_out_ch(och4), .MUX_busy(busy4)
    );

    stream_mux_n #(.N_CH(3)) dut3 (
        .MUX_clk(clk), .MUX_rst(rst), .MUX_en(en3), .MUX_mode(mode3), .MUX_sel(sel3),
        .MUX_in_valid(v3), .MUX_in_data(d3), .MUX_in_last(l3), .MUX_in_ready(r3),
        .MUX_out_valid(ov3), .MUX_out_data(od3), .MUX_out_last(ol3),
        .MUX_out_ready(ordy3), .MUX_out_ch(och3), .MUX_busy(busy3)
    );

    // Channels 0..3 feed dut4, channels 4..6 feed dut3 channels 0..2.
    beat_t inq [7][$];
    obs_t  exp4[$], exp3[$];

    int n_checks = 0, n_fails = 0;
    int cyc = 0, last_cyc = 0, wn = 0;
    bit bp_en = 1'b0, gap_en = 1'b0, chk_gap = 1'b0, chk_rdy0 = 1'b0, prev_last = 1'b0;
    logic  vv;
    beat_t bb;
    obs_t  got, want;

    task automatic chk(input string name, input logic [31:0] gotv, input logic [31:0] reqv);
        n_checks++;
        if (gotv !== reqv) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, gotv, reqv, cyc);
        end
    endtask

    task automatic pkt(input int k, input int len, input logic [7:0] base, input bit sb);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), 8'(base + i)};
            inq[k].push_back(b);
            if (sb) begin
                if (k < 4) exp4.push_back({2'(k), b});
                else       exp3.push_back({2'(k - 4), b});
            end
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 7; k++) inq[k].delete();
        exp4.delete();
        exp3.delete();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        flush();
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit all_idle();
        bit e;
        e = (exp4.size() == 0) && (exp3.size() == 0) && !busy4 && !busy3;
        for (int k = 0; k < 7; k++) if (inq[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        @(negedge clk); #4;
        while (!all_idle() && n < max) begin
            @(negedge clk); #4;
            n++;
        end
        chk(name, 32'(all_idle()), 32'd1);
    endtask

    // Upstream drivers: present queue heads at negedge, pop on handshakes seen just before posedge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 7; k++) begin
                vv = (inq[k].size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
                bb = (inq[k].size() > 0) ? inq[k][0] : '0;
                if (k < 4) begin
                    v4[k] = vv; l4[k] = bb[DW]; d4[k*DW +: DW] = bb[DW-1:0];
                end else begin
                    v3[k-4] = vv; l3[k-4] = bb[DW]; d3[(k-4)*DW +: DW] = bb[DW-1:0];
                end
            end
            ordy4 = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (!rst) begin
                for (int k = 0; k < 7; k++) begin
                    if (k < 4 ? (v4[k] && r4[k]) : (v3[k-4] && r3[k-4])) void'(inq[k].pop_front());
                end
            end
        end
    end

    // Output monitor: compare every accepted output beat against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk); #4;
            if (!rst) begin
                if (chk_rdy0) chk("fixed_ready_ch0", 32'(r4[0]), 32'd0);
                if (ov4 && ordy4) begin
                    got = {och4, ol4, od4};
                    if (exp4.size() == 0) begin
                        n_checks++; n_fails++;
                        $display("FAIL out4_unexpected: got 0x%0h, required no beat (cycle %0d)", got, cyc);
                    end else begin
                        want = exp4.pop_front();
                        chk("out4_beat", 32'(got), 32'(want));
                    end
                    if (chk_gap && prev_last) chk("rr_bubble", 32'(cyc - last_cyc), 32'd2);
                    prev_last = ol4;
                    last_cyc  = cyc;
                end
                if (ov3 && ordy3) begin
                    got = {och3, ol3, od3};
                    if (exp3.size() == 0) begin
                        n_checks++; n_fails++;
                        $display("FAIL out3_unexpected: got 0x%0h, required no beat (cycle %0d)", got, cyc);
                    end else begin
                        want = exp3.pop_front();
                        chk("out3_beat", 32'(got), 32'(want));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with all dut4 channels valid, then round-robin 0,1,2,3,0 of 2-beat packets.
        en4 = 1'b1; mode4 = MODE_RR; chk_gap = 1'b1;
        pkt(0, 2, 8'h00, 1'b1);
        pkt(1, 2, 8'h10, 1'b1);
        pkt(2, 2, 8'h20, 1'b1);
        pkt(3, 2, 8'h30, 1'b1);
        pkt(0, 2, 8'h40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #4;
            chk("reset_outputs", 32'({ov4, ol4, od4, och4, busy4, r4}), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #4 chk("no_grant_at_release", 32'({busy4, r4, ov4}), 32'd0);
        @(negedge clk); #4;
        chk("grant_after_release", 32'(busy4), 32'd1);
        wait_idle("rr_drain", 200);
        chk_gap = 1'b0;

        // Fixed select of ch2 while ch0 also holds valid data.
        do_reset(1);
        mode4 = MODE_FIXED; sel4 = 2'd2; en4 = 1'b1;
        pkt(0, 2, 8'h05, 1'b0);
        pkt(2, 3, 8'hA1, 1'b1);
        chk_rdy0 = 1'b1;
        wn = 0;
        do begin @(negedge clk); #4; wn++; end while (exp4.size() != 0 && wn < 100);
        chk("fixed_drain", 32'(exp4.size()), 32'd0);
        repeat (3) @(negedge clk);
        #4 chk("fixed_no_other_grant", 32'({busy4, ov4}), 32'd0);
        chk_rdy0 = 1'b0;

        // Three-channel instance: round-robin wrap with ch0/ch2 only, then out-of-range select.
        do_reset(1);
        en4 = 1'b0; mode3 = MODE_RR; sel3 = 2'd0; en3 = 1'b1;
        pkt(4, 1, 8'h30, 1'b0); pkt(4, 1, 8'h31, 1'b0);
        pkt(6, 1, 8'h50, 1'b0); pkt(6, 1, 8'h51, 1'b0);
        exp3.push_back({2'd0, 1'b1, 8'h30});
        exp3.push_back({2'd2, 1'b1, 8'h50});
        exp3.push_back({2'd0, 1'b1, 8'h31});
        exp3.push_back({2'd2, 1'b1, 8'h51});
        wait_idle("wrap_drain", 100);
        @(negedge clk);
        mode3 = MODE_FIXED; sel3 = 2'd3;
        pkt(4, 1, 8'h32, 1'b0);
        pkt(6, 1, 8'h52, 1'b0);
        repeat (4) @(negedge clk);
        #4 chk("sel_out_of_range", 32'({busy3, r3, ov3}), 32'd0);
        en3 = 1'b0;

        // Random backpressure and valid gaps; controls change while ch1 is locked.
        do_reset(1);
        mode4 = MODE_RR; en4 = 1'b1; bp_en = 1'b1; gap_en = 1'b1;
        pkt(1, 4, 8'h10, 1'b1);
        pkt(3, 3, 8'h60, 1'b1);
        wn = 0;
        do begin @(negedge clk); #4; wn++; end while (!busy4 && wn < 50);
        chk("lock_seen", 32'(busy4), 32'd1);
        @(negedge clk);
        mode4 = MODE_FIXED; sel4 = 2'd3; en4 = 1'b0;
        wn = 0;
        do begin @(negedge clk); #4; wn++; end while ((inq[1].size() != 0 || busy4) && wn < 200);
        chk("locked_pkt_done", 32'(inq[1].size()), 32'd0);
        repeat (4) @(negedge clk);
        #4 chk("en_blocks_grant", 32'(busy4), 32'd0);
        @(negedge clk);
        en4 = 1'b1;
        wait_idle("bp_drain", 400);
        bp_en = 1'b0; gap_en = 1'b0;

        // Reset mid-packet on ch2 after rr_ptr has moved to 2; arbitration must restart at ch0.
        do_reset(1);
        mode4 = MODE_RR; en4 = 1'b1;
        pkt(1, 2, 8'h20, 1'b1);
        wait_idle("pre_reset_pkt", 50);
        @(negedge clk);
        pkt(2, 4, 8'h70, 1'b1);
        wn = 0;
        do begin @(negedge clk); #4; wn++; end while (exp4.size() > 3 && wn < 50);
        chk("first_beat_out", 32'(exp4.size()), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        flush();
        @(negedge clk);
        rst = 1'b0;
        pkt(0, 2, 8'h80, 1'b1);
        pkt(2, 2, 8'h90, 1'b1);
        #4 chk("idle_after_reset", 32'({busy4, r4}), 32'd0);
        wait_idle("restart_drain", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
